// File: rtl/multi_debouncer.sv
// Multi-channel button debouncer: 2-flop sync, shared tick prescaler, edge pulses.
// Define DEBOUNCE_HOLD_EN to build the per-channel long-press (o_HOLD) counters.
module multi_debouncer #(
  parameter int   p_CHANNELS     = 4,
  parameter int   p_DIVIDER      = 5,
  parameter int   p_STABLE_TICKS = 8,
  parameter int   p_HOLD_TICKS   = 1000,
  parameter logic p_RESET_LEVEL  = 1'b0
) (
  input  logic                  i_SYS_CLOCK,
  input  logic                  i_RST_N,
  input  logic [p_CHANNELS-1:0] i_BTN,
  output logic [p_CHANNELS-1:0] o_BTN,
  output logic [p_CHANNELS-1:0] o_RISE,
  output logic [p_CHANNELS-1:0] o_FALL,
  output logic [p_CHANNELS-1:0] o_HOLD
);

  localparam int PW = (p_DIVIDER > 1) ? $clog2(p_DIVIDER) : 1;
  localparam int CW = $clog2(p_STABLE_TICKS + 1);
  localparam logic [PW-1:0] DIV_LAST = PW'(p_DIVIDER - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(p_STABLE_TICKS - 1);
  localparam logic [p_CHANNELS-1:0] RST_VEC = {p_CHANNELS{p_RESET_LEVEL}};

  logic [p_CHANNELS-1:0] sync1_q, sync2_q;
  logic [PW-1:0] presc_q, presc_d;
  logic tick;
  logic [p_CHANNELS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [p_CHANNELS-1:0] btn_q, btn_d;
  logic [p_CHANNELS-1:0] rise_q, rise_d;
  logic [p_CHANNELS-1:0] fall_q, fall_d;

  always_ff @(posedge i_SYS_CLOCK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      sync1_q <= RST_VEC;
      sync2_q <= RST_VEC;
    end else begin
      sync1_q <= i_BTN;
      sync2_q <= sync1_q;
    end
  end

  assign tick    = (presc_q == DIV_LAST);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  // Counter holds while a mismatch waits for the next tick, clears on agreement.
  always_comb begin
    cnt_d  = '0;
    btn_d  = btn_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < p_CHANNELS; i++) begin
      if (sync2_q[i] != btn_q[i]) begin
        cnt_d[i] = cnt_q[i];
        if (tick) begin
          if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]  = '0;
            btn_d[i]  = ~btn_q[i];
            rise_d[i] = ~btn_q[i];
            fall_d[i] = btn_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_SYS_CLOCK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      presc_q <= '0;
      cnt_q   <= '0;
      btn_q   <= RST_VEC;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_BTN  = btn_q;
  assign o_RISE = rise_q;
  assign o_FALL = fall_q;

`ifdef DEBOUNCE_HOLD_EN
  localparam int HW = $clog2(p_HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(p_HOLD_TICKS);

  logic [p_CHANNELS-1:0][HW-1:0] hold_q, hold_d;

  // Clearing on btn_d drops o_HOLD on the same edge the debounced level falls.
  always_comb begin
    hold_d = hold_q;
    for (int i = 0; i < p_CHANNELS; i++) begin
      if (!btn_d[i]) begin
        hold_d[i] = '0;
      end else if (tick && btn_q[i] && hold_q[i] != HOLD_MAX) begin
        hold_d[i] = hold_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_SYS_CLOCK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  always_comb begin
    o_HOLD = '0;
    for (int i = 0; i < p_CHANNELS; i++) begin
      o_HOLD[i] = (hold_q[i] == HOLD_MAX);
    end
  end
`else
  if (p_HOLD_TICKS >= 1) begin : g_hold_off
    assign o_HOLD = '0;
  end
`endif

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter p_CHANNELS, default 4: number of independent debounced inputs; legal range 1..32.
REQ-002 Parameter p_DIVIDER, default 5: system clocks per sample tick; legal range >= 1.
REQ-003 Parameter p_STABLE_TICKS, default 8: consecutive ticks a new level must persist before it is accepted; legal range >= 1.
REQ-004 Parameter p_HOLD_TICKS, default 1000: ticks of continuous debounced-high before a long-press is flagged; legal range >= 1.
REQ-005 Parameter p_RESET_LEVEL, default 0: level loaded into synchronisers and debounced state at reset, applied to all channels.
REQ-006 i_SYS_CLOCK  input  1  system clock; all state updates on the rising edge.
REQ-007 i_RST_N  input  1  reset, asynchronous, active-low.
REQ-008 i_BTN  input  p_CHANNELS  raw asynchronous button/switch levels, one bit per channel.
REQ-009 o_BTN  output  p_CHANNELS  debounced levels.
REQ-010 o_RISE  output  p_CHANNELS  one-cycle pulse per channel when o_BTN goes 0->1.
REQ-011 o_FALL  output  p_CHANNELS  one-cycle pulse per channel when o_BTN goes 1->0.
REQ-012 o_HOLD  output  p_CHANNELS  long-press flag per channel.

Function
REQ-013 Each i_BTN bit SHALL pass through a dedicated two-flop synchroniser; only the second-stage value (sync level) is used downstream.
REQ-014 One shared prescaler SHALL count 0..p_DIVIDER-1 and wrap; tick is high for exactly one clock when the count equals p_DIVIDER-1; with p_DIVIDER=1, tick is high every clock.
REQ-015 Each channel SHALL hold a counter of width clog2(p_STABLE_TICKS+1).
REQ-016 Counter rule, per channel: sync level equal to o_BTN -> counter clears to 0 on that clock, regardless of tick.
REQ-017 Counter rule, per channel: sync level differs from o_BTN and tick high -> counter increments.
REQ-018 When a tick would bring the counter to p_STABLE_TICKS, o_BTN SHALL toggle on that same edge and the counter SHALL clear to 0.
REQ-019 o_RISE/o_FALL SHALL assert for exactly the one clock in which the new o_BTN value is first visible, matching the transition direction; never both on the same channel.
REQ-020 Any glitch shorter than one tick-to-tick interval at the sync level SHALL reset the counter and produce no output change.
REQ-021 Latency from a clean i_BTN step: o_BTN changes no earlier than 2 + (p_STABLE_TICKS-1)*p_DIVIDER + 1 clocks and no later than 2 + p_STABLE_TICKS*p_DIVIDER + 1 clocks.
REQ-022 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be handled as if alone.
REQ-023 The prescaler SHALL be free-running and never stalled or reset by channel activity.

Reset
REQ-024 While i_RST_N=0: synchronisers and o_BTN = p_RESET_LEVEL on every bit; counters, prescaler, o_RISE, o_FALL, o_HOLD and hold counters = 0.
REQ-025 Reset assertion mid-debounce SHALL abort it immediately with no edge pulse; the first tick after release occurs p_DIVIDER clocks after the first active edge.
REQ-026 No o_RISE/o_FALL pulse SHALL be generated by reset or its release, even if i_BTN differs from p_RESET_LEVEL; such a difference is debounced normally afterwards.

Configuration
REQ-027 Macro DEBOUNCE_HOLD_EN defined: each channel SHALL contain a hold counter, saturating at p_HOLD_TICKS, that increments on tick while o_BTN=1 and clears whenever o_BTN=0.
REQ-028 With DEBOUNCE_HOLD_EN defined, o_HOLD SHALL be high whenever the hold counter equals p_HOLD_TICKS and drop on the same edge o_BTN falls.
REQ-029 Macro DEBOUNCE_HOLD_EN undefined: no hold logic SHALL be synthesised, the o_HOLD port SHALL remain present, and o_HOLD SHALL be constant 0.

Verification (p_CHANNELS=4, p_DIVIDER=4, p_STABLE_TICKS=3, p_HOLD_TICKS=5, p_RESET_LEVEL=0)
REQ-030 Clean step: ch0 0->1, held -> o_BTN[0] rises 11..15 clocks later, o_RISE[0] high exactly 1 clock, other channels unchanged.
REQ-031 Bounce: ch1 toggles every 3 clocks for 40 clocks, then holds 1 -> no o_BTN[1] change during bounce; a single rise within 15 clocks of the final edge.
REQ-032 Simultaneous: ch2 rises and ch3 falls (ch3 previously settled high) on the same clock -> o_RISE[2] and o_FALL[3] pulse in the same cycle.
REQ-033 Reset mid-debounce: ch0 high for 8 clocks, then i_RST_N low 2 clocks -> o_BTN=0, no pulses; after release, rise within 15 clocks if ch0 is still high.
REQ-034 Hold: ch0 settled high for 25 clocks past its rise -> DEBOUNCE_HOLD_EN defined: o_HOLD[0]=1 after 5 ticks (20 clocks), cleared with the fall; undefined: o_HOLD stays 0.
REQ-035 Reset-level mismatch: i_BTN=4'hF held through reset release -> no pulse at release; o_RISE=4'hF pulses once, 11..15 clocks after release.
